// File: rtl/mult_acc_pkg.sv
// Shared types and helpers for the pipelined multiply-accumulate unit.
// Sideband is carried as a packed struct; the id field is sized for the widest supported tag.
package mult_acc_pkg;

  localparam int SB_ID_MAX = 16;

  function automatic int calc_p_width(input int a_w, input int b_w, input int guard);
    return a_w + b_w + guard;
  endfunction

  typedef struct packed {
    logic                 is_signed;
    logic                 acc_en;
    logic                 acc_clr;
    logic [SB_ID_MAX-1:0] id;
  } op_sb_t;

  // Unsigned ops flag carry-out; signed ops flag a sign flip of two like-signed addends.
  function automatic logic add_overflow(input logic is_signed, input logic carry,
                                        input logic acc_msb, input logic add_msb,
                                        input logic sum_msb);
    if (is_signed) return (acc_msb == add_msb) && (sum_msb != acc_msb);
    return carry;
  endfunction

endpackage

// File: rtl/mult_pipe_core.sv
// Extended multiplier followed by PIPE_STAGES-1 product/sideband register stages.
// Latency: PIPE_STAGES-1 adv-cycles (combinational pass-through when PIPE_STAGES=1).
// Backpressure: every stage holds while adv=0; reset clears all stage valids.
module mult_pipe_core
  import mult_acc_pkg::*;
#(
  parameter int A_WIDTH     = 28,
  parameter int B_WIDTH     = 20,
  parameter int P_WIDTH     = 56,
  parameter int PIPE_STAGES = 3
) (
  input  logic               clock0,
  input  logic               reset,
  input  logic               adv,
  input  logic               in_vld,
  input  logic [A_WIDTH-1:0] a,
  input  logic [B_WIDTH-1:0] b,
  input  op_sb_t             in_sb,
  output logic               fin_vld,
  output logic [P_WIDTH-1:0] fin_prod,
  output op_sb_t             fin_sb
);

  localparam int FW = A_WIDTH + B_WIDTH + 2;

  logic signed [A_WIDTH:0]   a_s;
  logic signed [B_WIDTH:0]   b_s;
  logic signed [FW-1:0]      prod_s;
  logic        [P_WIDTH-1:0] prod_ext;

  // One extra top bit makes a single signed multiplier serve both modes.
  assign a_s      = {in_sb.is_signed & a[A_WIDTH-1], a};
  assign b_s      = {in_sb.is_signed & b[B_WIDTH-1], b};
  assign prod_s   = FW'(a_s) * FW'(b_s);
  assign prod_ext = P_WIDTH'(prod_s);

  generate
    if (PIPE_STAGES == 1) begin : g_comb
      assign fin_vld  = in_vld;
      assign fin_prod = prod_ext;
      assign fin_sb   = in_sb;
    end else begin : g_regs
      localparam int N = PIPE_STAGES - 1;

      logic               vld_q  [N];
      logic [P_WIDTH-1:0] prod_q [N];
      op_sb_t             sb_q   [N];

      always_ff @(posedge clock0) begin
        if (reset) begin
          for (int i = 0; i < N; i++) begin
            vld_q[i]  <= 1'b0;
            prod_q[i] <= '0;
            sb_q[i]   <= '0;
          end
        end else if (adv) begin
          vld_q[0]  <= in_vld;
          prod_q[0] <= prod_ext;
          sb_q[0]   <= in_sb;
          for (int i = 1; i < N; i++) begin
            vld_q[i]  <= vld_q[i-1];
            prod_q[i] <= prod_q[i-1];
            sb_q[i]   <= sb_q[i-1];
          end
        end
      end

      assign fin_vld  = vld_q[N-1];
      assign fin_prod = prod_q[N-1];
      assign fin_sb   = sb_q[N-1];
    end
  endgenerate

endmodule

// File: rtl/mult_acc_pipe_param.sv
// Pipelined signed/unsigned multiplier with optional accumulate into Y and per-result overflow.
// Latency: PIPE_STAGES adv-cycles from accept to out_valid; 1 op/cycle with out_ready=1.
// Backpressure: global stall, in_ready = !out_valid || out_ready (0 during reset).
module mult_acc_pipe_param
  import mult_acc_pkg::*;
#(
  parameter  int A_WIDTH     = 28,
  parameter  int B_WIDTH     = 20,
  parameter  int ACC_GUARD   = 8,
  parameter  int PIPE_STAGES = 3,
  parameter  int ID_WIDTH    = 4,
  localparam int P_WIDTH     = calc_p_width(A_WIDTH, B_WIDTH, ACC_GUARD)
) (
  input  logic                clock0,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [A_WIDTH-1:0]  A,
  input  logic [B_WIDTH-1:0]  B,
  input  logic                is_signed,
  input  logic                acc_en,
  input  logic                acc_clr,
  input  logic [ID_WIDTH-1:0] id,
  output logic [P_WIDTH-1:0]  Y,
  output logic                overflow,
  output logic [ID_WIDTH-1:0] id_out,
  output logic                out_valid,
  input  logic                out_ready
);

  logic               adv;
  logic               accept;
  op_sb_t             in_sb;
  op_sb_t             fin_sb;
  logic               fin_vld;
  logic [P_WIDTH-1:0] fin_prod;
  logic [P_WIDTH-1:0] sum;
  logic               carry;
  logic               unused_id_hi;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && !reset;
  assign accept   = in_valid && in_ready;

  always_comb begin
    in_sb                    = '0;
    in_sb.is_signed          = is_signed;
    in_sb.acc_en             = acc_en;
    in_sb.acc_clr            = acc_clr;
    in_sb.id[ID_WIDTH-1:0]   = id;
  end

  mult_pipe_core #(
    .A_WIDTH    (A_WIDTH),
    .B_WIDTH    (B_WIDTH),
    .P_WIDTH    (P_WIDTH),
    .PIPE_STAGES(PIPE_STAGES)
  ) u_core (
    .clock0  (clock0),
    .reset   (reset),
    .adv     (adv),
    .in_vld  (accept),
    .a       (A),
    .b       (B),
    .in_sb   (in_sb),
    .fin_vld (fin_vld),
    .fin_prod(fin_prod),
    .fin_sb  (fin_sb)
  );

  // Y doubles as the accumulator; the sum wraps modulo 2^P_WIDTH.
  assign {carry, sum} = {1'b0, Y} + {1'b0, fin_prod};

  always_ff @(posedge clock0) begin
    if (reset) begin
      Y         <= '0;
      overflow  <= 1'b0;
      id_out    <= '0;
      out_valid <= 1'b0;
    end else if (adv) begin
      out_valid <= fin_vld;
      if (fin_vld) begin
        id_out <= fin_sb.id[ID_WIDTH-1:0];
        if (!fin_sb.acc_en || fin_sb.acc_clr) begin
          Y        <= fin_prod;
          overflow <= 1'b0;
        end else begin
          Y        <= sum;
          overflow <= add_overflow(fin_sb.is_signed, carry, Y[P_WIDTH-1],
                                   fin_prod[P_WIDTH-1], sum[P_WIDTH-1]);
        end
      end
    end
  end

  assign unused_id_hi = ^fin_sb.id;

endmodule

// File: tb/tb_mult_acc_pipe_param.sv
// Scoreboard bench: three instances (default, zero-guard, 4x4 zero-guard) share one stimulus stream.
// Expected results come from an arithmetic reference model; a monitor pops and compares on each handshake.
module tb_mult_acc_pipe_param;

  localparam int AW = 28;
  localparam int BW = 20;
  localparam int PS = 3;
  localparam int IW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [AW-1:0] A = '0;
  logic [BW-1:0] B = '0;
  logic          is_signed = 1'b0;
  logic          acc_en = 1'b0;
  logic          acc_clr = 1'b0;
  logic [IW-1:0] id = '0;
  logic          out_ready = 1'b1;

  logic          in_ready0, in_ready1, in_ready2;
  logic          out_valid0, out_valid1, out_valid2;
  logic          overflow0, overflow1, overflow2;
  logic [IW-1:0] id_out0, id_out1, id_out2;
  logic [55:0]   Y0;
  logic [47:0]   Y1;
  logic [7:0]    Y2;

  mult_acc_pipe_param #(.A_WIDTH(28), .B_WIDTH(20), .ACC_GUARD(8), .PIPE_STAGES(PS), .ID_WIDTH(IW)) u0 (
    .clock0(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0), .A(A), .B(B),
    .is_signed(is_signed), .acc_en(acc_en), .acc_clr(acc_clr), .id(id), .Y(Y0),
    .overflow(overflow0), .id_out(id_out0), .out_valid(out_valid0), .out_ready(out_ready));

  mult_acc_pipe_param #(.A_WIDTH(28), .B_WIDTH(20), .ACC_GUARD(0), .PIPE_STAGES(PS), .ID_WIDTH(IW)) u1 (
    .clock0(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1), .A(A), .B(B),
    .is_signed(is_signed), .acc_en(acc_en), .acc_clr(acc_clr), .id(id), .Y(Y1),
    .overflow(overflow1), .id_out(id_out1), .out_valid(out_valid1), .out_ready(out_ready));

  mult_acc_pipe_param #(.A_WIDTH(4), .B_WIDTH(4), .ACC_GUARD(0), .PIPE_STAGES(PS), .ID_WIDTH(IW)) u2 (
    .clock0(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2), .A(A[3:0]), .B(B[3:0]),
    .is_signed(is_signed), .acc_en(acc_en), .acc_clr(acc_clr), .id(id), .Y(Y2),
    .overflow(overflow2), .id_out(id_out2), .out_valid(out_valid2), .out_ready(out_ready));

  typedef struct {
    logic [63:0]   y [3];
    logic          o [3];
    logic [IW-1:0] id;
    int            lit_d;
    logic [63:0]   lit_y;
    logic          lit_o;
  } exp_t;

  exp_t        sbq[$];
  logic [63:0] acc_m [3] = '{64'd0, 64'd0, 64'd0};
  int          aw_t [3] = '{28, 28, 4};
  int          bw_t [3] = '{20, 20, 4};
  int          pw_t [3] = '{56, 48, 8};
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          bp_mode = 0;
  int          hold_until = 0;

  function automatic logic [63:0] mask(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic longint sval(input logic [63:0] v, input int w);
    logic [63:0] m;
    m = v & mask(w);
    if (m[w-1]) return longint'(m) - longint'(64'd1 << w);
    return longint'(m);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: true integer product, then wrap/range-check against each result width.
  task automatic model_op(input logic [63:0] a, input logic [63:0] b, input logic sg,
                          input logic ae, input logic ac, output exp_t e);
    longint av, bv, p, sv, mx;
    logic [63:0] pm, s;
    for (int d = 0; d < 3; d++) begin
      av = sg ? sval(a, aw_t[d]) : longint'(a & mask(aw_t[d]));
      bv = sg ? sval(b, bw_t[d]) : longint'(b & mask(bw_t[d]));
      p  = av * bv;
      pm = 64'(p) & mask(pw_t[d]);
      if (!ae || ac) begin
        acc_m[d] = pm;
        e.o[d]   = 1'b0;
      end else if (!sg) begin
        s        = acc_m[d] + pm;
        e.o[d]   = (s > mask(pw_t[d]));
        acc_m[d] = s & mask(pw_t[d]);
      end else begin
        sv       = sval(acc_m[d], pw_t[d]) + sval(pm, pw_t[d]);
        mx       = (longint'(1) <<< (pw_t[d] - 1)) - 1;
        e.o[d]   = (sv > mx) || (sv < -mx - 1);
        acc_m[d] = 64'(sv) & mask(pw_t[d]);
      end
      e.y[d] = acc_m[d];
    end
  endtask

  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic sg,
                       input logic ae, input logic ac, input logic [IW-1:0] t,
                       input int ld = -1, input logic [63:0] ly = 64'd0, input logic lo = 1'b0);
    exp_t e;
    int   w;
    w = 0;
    A = a[AW-1:0]; B = b[BW-1:0]; is_signed = sg; acc_en = ae; acc_clr = ac; id = t;
    in_valid = 1'b1;
    #1;
    while (!in_ready0 && w < 300) begin
      @(negedge clk); #1; w++;
    end
    if (!in_ready0) begin
      n_cmp++; n_bad++;
      $display("FAIL issue_timeout: in_ready stuck 0 for id %0d", t);
      @(negedge clk);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_op(a, b, sg, ae, ac, e);
    e.id = t; e.lit_d = ld; e.lit_y = ly; e.lit_o = lo;
    sbq.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (cyc < hold_until)  out_ready = 1'b0;
    else if (bp_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
    else                   out_ready = 1'b1;
  end

  initial begin : monitor
    exp_t e;
    logic [63:0] ly;
    logic        lo;
    forever begin
      @(negedge clk); #2;
      if (!reset) begin
        if (out_valid0 && !out_ready) begin
          chk("in_ready_during_stall", 64'(in_ready0), 64'd0);
          if (sbq.size() > 0) chk("y_held_in_stall", 64'(Y0), sbq[0].y[0]);
        end
        if (out_valid0 && out_ready) begin
          if (sbq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_output: id %0d Y %h with empty scoreboard", id_out0, Y0);
          end else begin
            e = sbq.pop_front();
            chk("id_out",     64'(id_out0),    64'(e.id));
            chk("y_g8",       64'(Y0),         e.y[0]);
            chk("ovf_g8",     64'(overflow0),  64'(e.o[0]));
            chk("valid_g0",   64'(out_valid1), 64'd1);
            chk("y_g0",       64'(Y1),         e.y[1]);
            chk("ovf_g0",     64'(overflow1),  64'(e.o[1]));
            chk("valid_4x4",  64'(out_valid2), 64'd1);
            chk("y_4x4",      64'(Y2),         e.y[2]);
            chk("ovf_4x4",    64'(overflow2),  64'(e.o[2]));
            if (e.lit_d >= 0) begin
              case (e.lit_d)
                0:       begin ly = 64'(Y0); lo = overflow0; end
                1:       begin ly = 64'(Y1); lo = overflow1; end
                default: begin ly = 64'(Y2); lo = overflow2; end
              endcase
              chk("directed_y",   ly,      e.lit_y);
              chk("directed_ovf", 64'(lo), 64'(e.lit_o));
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    logic [63:0] ra, rb;
    repeat (2) @(negedge clk);
    chk("reset_out_valid", 64'(out_valid0), 64'd0);
    chk("reset_y",         64'(Y0),         64'd0);
    chk("reset_ovf",       64'(overflow0),  64'd0);
    chk("reset_id_out",    64'(id_out0),    64'd0);
    chk("reset_in_ready",  64'(in_ready0),  64'd0);
    reset = 1'b0;

    // Unsigned max, then small; signed -1 * 3.
    issue(64'hFFFFFFF, 64'hFFFFF, 1'b0, 1'b0, 1'b0, 4'd1, 0, 64'h0000FFFFEFF00001, 1'b0);
    issue(64'd1, 64'd2, 1'b0, 1'b0, 1'b0, 4'd2, 0, 64'd2, 1'b0);
    issue(64'hFFFFFFF, 64'h00003, 1'b1, 1'b0, 1'b0, 4'd3, 0, 64'hFFFFFFFFFFFFFD, 1'b0);

    // Accumulate chain with bubbles between ops.
    issue(64'd2, 64'd3, 1'b0, 1'b1, 1'b1, 4'd4, 0, 64'd6, 1'b0);
    repeat (2) @(negedge clk);
    issue(64'd4, 64'd5, 1'b0, 1'b1, 1'b0, 4'd5, 0, 64'd26, 1'b0);
    repeat (3) @(negedge clk);
    issue(64'd1, 64'd1, 1'b0, 1'b1, 1'b0, 4'd6, 0, 64'd27, 1'b0);
    @(negedge clk);
    issue(64'd7, 64'd1, 1'b0, 1'b0, 1'b0, 4'd7, 0, 64'd7, 1'b0);

    // Backpressure: ids 1..4 back-to-back while out_ready is held low.
    hold_until = cyc + 5;
    for (int i = 1; i <= 4; i++)
      issue(64'(i * 3), 64'(i + 10), 1'b0, 1'b0, 1'b0, IW'(i));
    repeat (8) @(negedge clk);

    // Overflow with zero guard bits: unsigned 28x20 and signed 4x4.
    issue(64'hFFFFFFF, 64'hFFFFF, 1'b0, 1'b0, 1'b0, 4'd8, 1, 64'hFFFFEFF00001, 1'b0);
    issue(64'hFFFFFFF, 64'hFFFFF, 1'b0, 1'b1, 1'b0, 4'd9, 1, 64'hFFFFDFE00002, 1'b1);
    issue(64'h8, 64'h8, 1'b1, 1'b1, 1'b1, 4'd10, 2, 64'h40, 1'b0);
    issue(64'h8, 64'h8, 1'b1, 1'b1, 1'b0, 4'd11, 2, 64'h80, 1'b1);

    // Reset mid-stream discards in-flight ops; first op afterwards accumulates onto 0.
    issue(64'd11, 64'd13, 1'b0, 1'b0, 1'b0, 4'd12);
    issue(64'd17, 64'd19, 1'b0, 1'b1, 1'b0, 4'd13);
    issue(64'd23, 64'd29, 1'b0, 1'b1, 1'b0, 4'd14);
    reset = 1'b1;
    sbq.delete();
    for (int d = 0; d < 3; d++) acc_m[d] = 64'd0;
    @(negedge clk);
    chk("midreset_out_valid", 64'(out_valid0), 64'd0);
    chk("midreset_y",         64'(Y0),         64'd0);
    chk("midreset_ovf",       64'(overflow0),  64'd0);
    chk("midreset_in_ready",  64'(in_ready0),  64'd0);
    @(negedge clk);
    reset = 1'b0;
    issue(64'd5, 64'd7, 1'b0, 1'b1, 1'b0, 4'd15, 0, 64'd35, 1'b0);
    n = 0;
    while (!out_valid0 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("latency_after_reset", 64'(n + 1), 64'(PS));
    repeat (2) @(negedge clk);

    // Randomised traffic with random backpressure and bubbles.
    bp_mode = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      case ($urandom_range(0, 3))
        0:       ra = 64'hFFFFFFF;
        1:       ra = 64'h8000000;
        default: ra = {$urandom, $urandom};
      endcase
      case ($urandom_range(0, 3))
        0:       rb = 64'hFFFFF;
        1:       rb = 64'h80000;
        default: rb = {$urandom, $urandom};
      endcase
      issue(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 5) == 0), IW'($urandom));
    end

    bp_mode = 0;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk); n++;
    end
    chk("drain_empty", 64'(sbq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
